dma_bus_arbiter: RTL

Shares the 6502 core's single memory bus between the CPU and one DMA requester (video/blitter/loader). The arbiter stalls the core through its RDY input, and only on read cycles, because the core ignores RDY on writes. It then multiplexes the external address/data/RW bus to the DMA master for bounded bursts, with a guaranteed CPU slot between bursts. It sits between the CPU top level and the memory/IO decode.

---
 rtl/dma_bus_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter sharing the 6502 memory bus between the CPU and one DMA master.
// The CPU is stalled through RDY on read cycles only, and DMA bursts are bounded with a CPU cooldown.
module dma_bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CPU_SLOTS = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_rw,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_busy,
    output logic [15:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_DMA  = 2'd1,
        S_COOL = 2'd2
    } state_t;

    localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
    localparam logic [7:0] CPU_S  = 8'(CPU_SLOTS);

    state_t     state_q;
    logic [7:0] beat_q;
    logic [7:0] cool_q;
    logic [7:0] beat_d;

    assign beat_d = beat_q + 8'd1;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_CPU;
            beat_q  <= 8'd0;
            cool_q  <= 8'd0;
        end else begin
            case (state_q)
                S_CPU: begin
                    // Grant only on a CPU read: a write cannot be stalled by RDY.
                    if (dma_req && cpu_rw) begin
                        state_q <= S_DMA;
                        beat_q  <= 8'd0;
                    end
                end
                S_DMA: begin
                    if (!dma_req) begin
                        state_q <= S_CPU;
                    end else begin
                        beat_q <= beat_d;
                        if (beat_d == MAX_B) begin
                            state_q <= S_COOL;
                            cool_q  <= CPU_S;
                        end
                    end
                end
                S_COOL: begin
                    cool_q <= cool_q - 8'd1;
                    if (cool_q <= 8'd1) begin
                        state_q <= S_CPU;
                    end
                end
                default: state_q <= S_CPU;
            endcase
        end
    end

    // Outputs are qualified by res so an asynchronous reset hands the bus back mid-cycle.
    always_comb begin
        cpu_rdy   = 1'b1;
        dma_ack   = 1'b0;
        dma_busy  = 1'b0;
        mem_addr  = cpu_addr;
        mem_rw    = cpu_rw;
        mem_wdata = cpu_dout;
        if (res) begin
            case (state_q)
                S_CPU: begin
                    cpu_rdy = !(dma_req && cpu_rw);
                end
                S_DMA: begin
                    cpu_rdy   = 1'b0;
                    dma_busy  = 1'b1;
                    dma_ack   = dma_req;
                    mem_addr  = dma_addr;
                    mem_rw    = dma_req ? dma_rw : 1'b1;
                    mem_wdata = dma_wdata;
                end
                default: ;
            endcase
        end
    end

    assign dma_rdata   = mem_rdata;
    assign dbg_state_o = state_q;

endmodule
